// File: rtl/mem_wb_stage_if.sv
// MEM -> WB stage bus: memory-stage results in, writeback bus out.
// Optional WB_INSTRET_EN adds the 64-bit retired-instruction count.
interface mem_wb_stage_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  M_Stall;
  logic                  M_Flush;
  logic                  M_Valid;
  logic [ADDR_WIDTH-1:0] M_Rd;
  logic                  M_RegWrite;
  logic [1:0]            M_ResultSrc;
  logic [2:0]            M_Funct3;
  logic [DATA_WIDTH-1:0] M_ALUResult;
  logic [DATA_WIDTH-1:0] M_ReadData;
  logic [DATA_WIDTH-1:0] M_PCPlus4;

  logic                  W_Valid;
  logic [ADDR_WIDTH-1:0] W_Rd;
  logic                  W_RegWrite;
  logic [DATA_WIDTH-1:0] W_Result;
`ifdef WB_INSTRET_EN
  logic [63:0]           W_Instret;
`endif

  // Driver of the MEM side (pipeline / testbench).
  modport master (
    output M_Stall, M_Flush, M_Valid, M_Rd, M_RegWrite, M_ResultSrc, M_Funct3,
    output M_ALUResult, M_ReadData, M_PCPlus4,
`ifdef WB_INSTRET_EN
    input  W_Instret,
`endif
    input  W_Valid, W_Rd, W_RegWrite, W_Result
  );

  // The MEM/WB stage itself.
  modport slave (
    input  M_Stall, M_Flush, M_Valid, M_Rd, M_RegWrite, M_ResultSrc, M_Funct3,
    input  M_ALUResult, M_ReadData, M_PCPlus4,
`ifdef WB_INSTRET_EN
    output W_Instret,
`endif
    output W_Valid, W_Rd, W_RegWrite, W_Result
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register plus writeback result logic (load extract/extend, result mux).
// Optional feature macro: WB_INSTRET_EN adds a 64-bit retired-instruction counter.
module mem_wb_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input logic            clk,
  input logic            reset,
  mem_wb_stage_if.slave  bus
);

  logic                  valid_q;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic                  reg_write_q;
  logic [1:0]            result_src_q;
  logic [2:0]            funct3_q;
  logic [DATA_WIDTH-1:0] alu_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] pc4_q;

  // Stage register: flush beats stall, stall holds, otherwise capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= 1'b0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      result_src_q <= 2'b00;
      funct3_q     <= 3'b000;
      alu_q        <= '0;
      rdata_q      <= '0;
      pc4_q        <= '0;
    end else if (bus.M_Flush) begin
      valid_q      <= 1'b0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      result_src_q <= 2'b00;
      funct3_q     <= 3'b000;
      alu_q        <= '0;
      rdata_q      <= '0;
      pc4_q        <= '0;
    end else if (!bus.M_Stall) begin
      valid_q      <= bus.M_Valid;
      rd_q         <= bus.M_Rd;
      reg_write_q  <= bus.M_RegWrite;
      result_src_q <= bus.M_ResultSrc;
      funct3_q     <= bus.M_Funct3;
      alu_q        <= bus.M_ALUResult;
      rdata_q      <= bus.M_ReadData;
      pc4_q        <= bus.M_PCPlus4;
    end
  end

  logic [7:0]            load_byte;
  logic [15:0]           load_half;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [DATA_WIDTH-1:0] result;

  // Load lane select and extension, then the final result mux.
  always_comb begin
    load_byte = 8'h00;
    load_half = 16'h0000;
    load_ext  = rdata_q;
    result    = alu_q;

    unique case (alu_q[1:0])
      2'd0: load_byte = rdata_q[7:0];
      2'd1: load_byte = rdata_q[15:8];
      2'd2: load_byte = rdata_q[23:16];
      2'd3: load_byte = rdata_q[31:24];
    endcase
    // Halfword lane picks on off[1] only; misaligned off[0] is ignored.
    load_half = alu_q[1] ? rdata_q[31:16] : rdata_q[15:0];

    case (funct3_q)
      3'b000:  load_ext = {{(DATA_WIDTH-8){load_byte[7]}}, load_byte};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, load_byte};
      3'b001:  load_ext = {{(DATA_WIDTH-16){load_half[15]}}, load_half};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, load_half};
      default: load_ext = rdata_q;
    endcase

    unique case (result_src_q)
      2'b01:   result = load_ext;
      2'b10:   result = pc4_q;
      default: result = alu_q;
    endcase
  end

  assign bus.W_Valid    = valid_q;
  assign bus.W_Rd       = rd_q;
  assign bus.W_RegWrite = reg_write_q & valid_q & (rd_q != '0);
  assign bus.W_Result   = result;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q;

  // Count when a valid instruction leaves WB; a flush also moves it out even under stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instret_q <= 64'd0;
    end else if (valid_q && (bus.M_Flush || !bus.M_Stall)) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign bus.W_Instret = instret_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vector table, hand sequences for
// reset/stall/flush, and randomized traffic against a behavioural model.
module tb_mem_wb_stage;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  mem_wb_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  mem_wb_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [4:0]  rd;
    logic        we;
    logic [1:0]  src;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
    logic [4:0]  exp_rd;
    logic        exp_we;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model of the WB stage contents.
  logic        m_valid;
  logic [4:0]  m_rd;
  logic        m_we;
  logic [1:0]  m_src;
  logic [2:0]  m_f3;
  logic [31:0] m_alu;
  logic [31:0] m_rdata;
  logic [31:0] m_pc4;
  logic [63:0] m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic valid, input logic [4:0] rd, input logic we,
                       input logic [1:0] src, input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] rdata, input logic [31:0] pc4);
    bus.M_Valid     = valid;
    bus.M_Rd        = rd;
    bus.M_RegWrite  = we;
    bus.M_ResultSrc = src;
    bus.M_Funct3    = f3;
    bus.M_ALUResult = alu;
    bus.M_ReadData  = rdata;
    bus.M_PCPlus4   = pc4;
  endtask

  // Result computed from the ISA rules with shifts and signed casts.
  function automatic logic [31:0] ref_result(input logic [1:0] src, input logic [2:0] f3,
                                             input logic [31:0] alu, input logic [31:0] rdata,
                                             input logic [31:0] pc4);
    int unsigned off;
    logic [31:0] b;
    logic [31:0] h;
    logic [31:0] ld;
    off = int'(alu[1:0]);
    b   = (rdata >> (8 * off)) & 32'hFF;
    h   = (rdata >> (16 * (off / 2))) & 32'hFFFF;
    if (f3 == 3'd0)      ld = (b >= 32'h80) ? b - 32'h100 : b;
    else if (f3 == 3'd4) ld = b;
    else if (f3 == 3'd1) ld = (h >= 32'h8000) ? h - 32'h10000 : h;
    else if (f3 == 3'd5) ld = h;
    else                 ld = rdata;
    if (src == 2'd1)      return ld;
    else if (src == 2'd2) return pc4;
    else                  return alu;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    bus.M_Stall = 1'b0;
    bus.M_Flush = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    m_valid = 1'b0; m_rd = 5'd0; m_we = 1'b0; m_src = 2'd0; m_f3 = 3'd0;
    m_alu = 32'd0; m_rdata = 32'd0; m_pc4 = 32'd0; m_cnt = 64'd0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    do_reset();

    // Reset state
    #1;
    check("rst_valid", {63'd0, bus.W_Valid}, 64'd0);
    check("rst_rd", {59'd0, bus.W_Rd}, 64'd0);
    check("rst_we", {63'd0, bus.W_RegWrite}, 64'd0);
    check("rst_result", {32'd0, bus.W_Result}, 64'd0);
`ifdef WB_INSTRET_EN
    check("rst_instret", bus.W_Instret, 64'd0);
`endif

    // Directed vectors
    vecs.push_back('{1, 5, 1, 2'd0, 3'd2, 32'h1234_5678, 32'h0, 32'h0, 5, 1, 32'h1234_5678});
    vecs.push_back('{1, 5, 1, 2'd2, 3'd2, 32'h1234_5678, 32'h0, 32'h104, 5, 1, 32'h104});
    vecs.push_back('{1, 6, 1, 2'd1, 3'd0, 32'h3, 32'h80FF_7F01, 32'h0, 6, 1, 32'hFFFF_FF80});
    vecs.push_back('{1, 6, 1, 2'd1, 3'd4, 32'h1, 32'h80FF_7F01, 32'h0, 6, 1, 32'h0000_007F});
    vecs.push_back('{1, 6, 1, 2'd1, 3'd1, 32'h2, 32'h80FF_7F01, 32'h0, 6, 1, 32'hFFFF_80FF});
    vecs.push_back('{1, 6, 1, 2'd1, 3'd5, 32'h0, 32'h80FF_7F01, 32'h0, 6, 1, 32'h0000_7F01});
    vecs.push_back('{1, 6, 1, 2'd1, 3'd2, 32'h0, 32'h80FF_7F01, 32'h0, 6, 1, 32'h80FF_7F01});
    vecs.push_back('{1, 6, 1, 2'd1, 3'd1, 32'h3, 32'h80FF_7F01, 32'h0, 6, 1, 32'hFFFF_80FF});
    vecs.push_back('{1, 6, 1, 2'd1, 3'd4, 32'h2, 32'h80FF_7F01, 32'h0, 6, 1, 32'h0000_00FF});
    vecs.push_back('{1, 6, 1, 2'd1, 3'd3, 32'h1, 32'h80FF_7F01, 32'h0, 6, 1, 32'h80FF_7F01});
    vecs.push_back('{1, 9, 1, 2'd3, 3'd0, 32'hDEAD_BEEF, 32'h0, 32'h8, 9, 1, 32'hDEAD_BEEF});
    vecs.push_back('{1, 0, 1, 2'd0, 3'd2, 32'h55, 32'h0, 32'h0, 0, 0, 32'h55});
    vecs.push_back('{0, 5, 1, 2'd0, 3'd2, 32'h66, 32'h0, 32'h0, 5, 0, 32'h66});
    vecs.push_back('{1, 31, 0, 2'd0, 3'd2, 32'h77, 32'h0, 32'h0, 31, 0, 32'h77});

    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].rd, vecs[i].we, vecs[i].src, vecs[i].f3,
            vecs[i].alu, vecs[i].rdata, vecs[i].pc4);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_rd", i), {59'd0, bus.W_Rd}, {59'd0, vecs[i].exp_rd});
      check($sformatf("vec%0d_we", i), {63'd0, bus.W_RegWrite}, {63'd0, vecs[i].exp_we});
      check($sformatf("vec%0d_result", i), {32'd0, bus.W_Result}, {32'd0, vecs[i].exp_res});
    end

    // Asynchronous reset in the middle of a cycle
    drive(1'b1, 5'd12, 1'b1, 2'd0, 3'd2, 32'hCAFE_F00D, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    check("pre_rst_we", {63'd0, bus.W_RegWrite}, 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_valid", {63'd0, bus.W_Valid}, 64'd0);
    check("async_rst_rd", {59'd0, bus.W_Rd}, 64'd0);
    check("async_rst_we", {63'd0, bus.W_RegWrite}, 64'd0);
    check("async_rst_result", {32'd0, bus.W_Result}, 64'd0);
    do_reset();

    // Stall holds for three cycles while inputs change
    drive(1'b1, 5'd7, 1'b1, 2'd0, 3'd2, 32'hAAAA_5555, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    check("stall_load_rd", {59'd0, bus.W_Rd}, 64'd7);
    bus.M_Stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 5'($urandom_range(1, 31)), 1'b1, 2'($urandom), 3'($urandom),
            $urandom, $urandom, $urandom);
      @(posedge clk);
      #1;
      check($sformatf("stall%0d_valid", c), {63'd0, bus.W_Valid}, 64'd1);
      check($sformatf("stall%0d_rd", c), {59'd0, bus.W_Rd}, 64'd7);
      check($sformatf("stall%0d_we", c), {63'd0, bus.W_RegWrite}, 64'd1);
      check($sformatf("stall%0d_result", c), {32'd0, bus.W_Result}, 64'h0000_0000_AAAA_5555);
    end
    bus.M_Flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush_stall_valid", {63'd0, bus.W_Valid}, 64'd0);
    check("flush_stall_we", {63'd0, bus.W_RegWrite}, 64'd0);
    bus.M_Flush = 1'b0;
    bus.M_Stall = 1'b0;

`ifdef WB_INSTRET_EN
    // 4 valid instructions, one stall, two flush bubbles
    do_reset();
    for (int k = 0; k < 7; k++) begin
      bus.M_Stall = (k == 2);
      bus.M_Flush = (k >= 5);
      drive(1'b1, 5'(k + 1), 1'b1, 2'd0, 3'd2, 32'(k), 32'h0, 32'h0);
      @(posedge clk);
    end
    #1;
    check("instret_seq", bus.W_Instret, 64'd4);
    bus.M_Stall = 1'b0;
    bus.M_Flush = 1'b0;
`endif

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic st;
      logic fl;
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 7) == 0);
      bus.M_Stall = st;
      bus.M_Flush = fl;
      drive(1'($urandom_range(0, 4) != 0),
            ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
            1'($urandom), 2'($urandom), 3'($urandom), $urandom, $urandom, $urandom);
      @(posedge clk);
      if (m_valid && (fl || !st)) m_cnt = m_cnt + 64'd1;
      if (fl) begin
        m_valid = 1'b0; m_rd = 5'd0; m_we = 1'b0; m_src = 2'd0; m_f3 = 3'd0;
        m_alu = 32'd0; m_rdata = 32'd0; m_pc4 = 32'd0;
      end else if (!st) begin
        m_valid = bus.M_Valid; m_rd = bus.M_Rd; m_we = bus.M_RegWrite;
        m_src = bus.M_ResultSrc; m_f3 = bus.M_Funct3; m_alu = bus.M_ALUResult;
        m_rdata = bus.M_ReadData; m_pc4 = bus.M_PCPlus4;
      end
      #1;
      check($sformatf("rnd%0d_valid", n), {63'd0, bus.W_Valid}, {63'd0, m_valid});
      check($sformatf("rnd%0d_rd", n), {59'd0, bus.W_Rd}, {59'd0, m_rd});
      check($sformatf("rnd%0d_we", n), {63'd0, bus.W_RegWrite},
            {63'd0, m_we && m_valid && (m_rd != 5'd0)});
      check($sformatf("rnd%0d_result", n), {32'd0, bus.W_Result},
            {32'd0, ref_result(m_src, m_f3, m_alu, m_rdata, m_pc4)});
`ifdef WB_INSTRET_EN
      check($sformatf("rnd%0d_instret", n), bus.W_Instret, m_cnt);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
